water_level_matrix_scan: RTL and testbench

- Time-multiplexes the 5-column x 7-row LED matrix of the CPLD kit from one water-level code.
- Latches a 2-bit level code from the sensor path and presents it to the combinational level decoder.
- Takes the decoder's two column patterns (edge columns 0/4, inner columns 1-3) and scans one column at a time with blanking dead-time.
- Applies level changes only at frame boundaries and blinks the water column at critical level.

---
 rtl/water_level_matrix_scan.sv | 125 ++++++++++++
 tb/tb_water_level_matrix_scan.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/water_level_matrix_scan.sv
// Column-scanned driver for a 5x7 LED matrix showing a 2-bit water level.
// Level changes land on frame boundaries; critical level blinks the inner columns.
module water_level_matrix_scan #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] level_in,
  input  logic       level_we,
  output logic [1:0] level_sel,
  input  logic [6:0] dec_col_1,
  input  logic [6:0] dec_col_0,
  output logic [6:0] matrix_row,
  output logic [4:0] matrix_col,
  output logic       frame_done
);

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [15:0]     CNT_MAX = 16'(CLK_DIV - 1);
  localparam logic [15:0]     BLANK_N = 16'(BLANK_CYCLES);
  localparam logic [FC_W-1:0] FC_MAX  = FC_W'(BLINK_FRAMES - 1);

  logic [15:0]     r_count;
  logic [2:0]      r_col;
  logic [FC_W-1:0] r_frame_cnt;
  logic            r_blink;
  logic [1:0]      r_level_sel;
  logic [1:0]      r_pending;
  logic [6:0]      r_row_p1;
  logic [4:0]      r_col_p1;
  logic            r_frame_done_p1;

  logic            w_tick;
  logic            w_wrap;
  logic [1:0]      w_next_level;
  logic            w_crit;
  logic            w_inner;
  logic [6:0]      w_row_sel;
  logic [4:0]      w_col_sel;

  always_comb begin
    w_tick       = (r_count == CNT_MAX);
    w_wrap       = w_tick && (r_col == 3'd4);
    w_next_level = level_we ? level_in : r_pending;
    w_crit       = (r_level_sel == 2'b00);
    w_inner      = (r_col != 3'd0) && (r_col != 3'd4);
    w_col_sel    = ~(5'b00001 << r_col);
    // Blink masking is gated by the live level so a frame leaving critical never blanks.
    if (!w_inner)
      w_row_sel = dec_col_1;
    else if (w_crit && r_blink)
      w_row_sel = 7'b0000000;
    else
      w_row_sel = dec_col_0;
  end

  // Stage p0: scan position, level and blink state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count     <= '0;
      r_col       <= '0;
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
      r_level_sel <= 2'b00;
      r_pending   <= 2'b00;
    end else begin
      if (level_we)
        r_pending <= level_in;
      if (!enable) begin
        r_count     <= '0;
        r_col       <= '0;
        r_frame_cnt <= '0;
        r_blink     <= 1'b0;
      end else begin
        r_count <= w_tick ? 16'd0 : r_count + 16'd1;
        if (w_tick)
          r_col <= (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;
        if (w_wrap)
          r_level_sel <= w_next_level;
        if (!w_crit) begin
          r_frame_cnt <= '0;
          r_blink     <= 1'b0;
        end else if (w_wrap) begin
          if (r_frame_cnt == FC_MAX) begin
            r_frame_cnt <= '0;
            r_blink     <= ~r_blink;
          end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Stage p1: registered matrix drive and frame pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col_p1        <= 5'b11111;
      r_row_p1        <= 7'b0000000;
      r_frame_done_p1 <= 1'b0;
    end else if (!enable) begin
      r_col_p1        <= 5'b11111;
      r_row_p1        <= 7'b0000000;
      r_frame_done_p1 <= 1'b0;
    end else begin
      r_frame_done_p1 <= w_wrap;
      if (r_count < BLANK_N) begin
        r_col_p1 <= 5'b11111;
        r_row_p1 <= 7'b0000000;
      end else begin
        r_col_p1 <= w_col_sel;
        r_row_p1 <= w_row_sel;
      end
    end
  end

  assign level_sel  = r_level_sel;
  assign matrix_row = r_row_p1;
  assign matrix_col = r_col_p1;
  assign frame_done = r_frame_done_p1;

endmodule

// File: tb/tb_water_level_matrix_scan.sv
// Bench for water_level_matrix_scan: directed scenarios then random traffic,
// each cycle compared against a frame/slot-arithmetic reference model.
module tb_water_level_matrix_scan;

  localparam int CD = 4;
  localparam int BL = 1;
  localparam int BF = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] level_in = 2'b00;
  logic       level_we = 1'b0;
  logic [1:0] level_sel;
  logic [6:0] dec_col_1;
  logic [6:0] dec_col_0;
  logic [6:0] matrix_row;
  logic [4:0] matrix_col;
  logic       frame_done;

  int vectors = 0;
  int miscompares = 0;

  int         m_t = 0;
  int         m_cf = 0;
  logic [1:0] m_lvl = 2'b00;
  logic [1:0] m_pend = 2'b00;

  water_level_matrix_scan #(
    .CLK_DIV(CD), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .level_in(level_in), .level_we(level_we), .level_sel(level_sel),
    .dec_col_1(dec_col_1), .dec_col_0(dec_col_0),
    .matrix_row(matrix_row), .matrix_col(matrix_col), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Combinational level decoder of the kit
  always_comb begin
    dec_col_1 = 7'b1111111;
    case (level_sel)
      2'b00:   dec_col_0 = 7'b0000001;
      2'b01:   dec_col_0 = 7'b0000111;
      2'b10:   dec_col_0 = 7'b0011111;
      default: dec_col_0 = 7'b1111111;
    endcase
  end

  function automatic logic [6:0] pattern(input logic [1:0] lvl, input int c, input logic dark);
    if (c == 0 || c == 4) return 7'b1111111;
    if (dark) return 7'b0000000;
    case (lvl)
      2'b00:   return 7'b0000001;
      2'b01:   return 7'b0000111;
      2'b10:   return 7'b0011111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic w, input logic [1:0] li);
    logic [4:0] ecol;
    logic [6:0] erow;
    logic       efd;
    logic       wrap;
    int         off;
    int         c;
    reset = r; enable = e; level_we = w; level_in = li;
    ecol = 5'b11111; erow = 7'b0; efd = 1'b0; wrap = 1'b0;
    off = m_t % CD;
    c   = (m_t / CD) % 5;
    if (!r && e) begin
      wrap = (off == CD - 1) && (c == 4);
      efd  = wrap;
      if (off >= BL) begin
        ecol = ~(5'd1 << c);
        erow = pattern(m_lvl, c, (m_lvl == 2'b00) && (((m_cf / BF) % 2) == 1));
      end
    end
    if (r) begin
      m_t = 0; m_cf = 0; m_lvl = 2'b00; m_pend = 2'b00;
    end else begin
      if (w) m_pend = li;
      if (!e) begin
        m_t = 0; m_cf = 0;
      end else begin
        m_t = (m_t + 1) % (5 * CD);
        if (wrap) begin
          if (m_lvl == 2'b00) m_cf++;
          m_lvl = m_pend;
        end
      end
      if (m_lvl != 2'b00) m_cf = 0;
    end
    @(posedge clock);
    #1;
    chk("matrix_col", 32'(matrix_col), 32'(ecol));
    chk("matrix_row", 32'(matrix_row), 32'(erow));
    chk("frame_done", 32'(frame_done), 32'(efd));
    chk("level_sel", 32'(level_sel), 32'(m_lvl));
    chk("col_onehot", 32'($countones(~matrix_col) <= 1), 32'd1);
  endtask

  initial begin
    int fd_count;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    chk("first_lit_col", 32'(matrix_col), 32'h1e);
    chk("first_lit_row", 32'(matrix_row), 32'h7f);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b11);
    chk("no_midframe_change", 32'(level_sel), 32'd0);
    fd_count = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'b00);
      if (frame_done) fd_count++;
    end
    chk("frame_done_rate", 32'(fd_count), 32'd2);

    step(1'b0, 1'b1, 1'b1, 2'b01);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b0, 2'b00);

    step(1'b0, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 180; i++) step(1'b0, 1'b1, 1'b0, 2'b00);

    for (int i = 0; i < 20 && m_t != 5 * CD - 1; i++) step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b10);
    chk("wrap_write", 32'(level_sel), 32'd2);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 2'b00);

    for (int i = 0; i < 20 && !(((m_t / CD) % 5) == 3 && (m_t % CD) == 1); i++)
      step(1'b0, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, (i == 2), 2'b01);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00);
    chk("reset_level", 32'(level_sel), 32'd0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0, 2'b00);

    for (int i = 0; i < 1500; i++) begin
      logic [1:0] li;
      li = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0),
           ($urandom_range(0, 7) == 0), li);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
